// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RISC-V pipeline.
// Decodes the EX/MEM values and drives the dmem/imem write ports and the UART
// strobes combinationally. It serves the MMIO status, UART and performance-counter
// space, and registers the results into the MEM/WB pipeline registers.
module mem_stage #(
    parameter int          DMEM_AW = 14,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        mem_pc,
    input  logic [31:0]        mem_alu,
    input  logic [31:0]        mem_rd2,
    input  logic [31:0]        mem_inst,
    input  logic               mem_br_suc,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [3:0]         imem_we,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [31:0]        mem_din,
    output logic [7:0]         uart_tx_data_in,
    output logic               uart_tx_data_in_valid,
    input  logic               uart_tx_data_in_ready,
    input  logic [7:0]         uart_rx_data_out,
    input  logic               uart_rx_data_out_valid,
    output logic               uart_rx_data_out_ready,
    output logic [31:0]        wb_pc,
    output logic [31:0]        wb_alu,
    output logic [31:0]        wb_mmio_rdata,
    output logic [31:0]        wb_inst
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // MMIO word offsets relative to 0x8000_0000
    localparam logic [27:0] MMIO_UART_STAT = 28'h000_0000;
    localparam logic [27:0] MMIO_UART_RX   = 28'h000_0004;
    localparam logic [27:0] MMIO_UART_TX   = 28'h000_0008;
    localparam logic [27:0] MMIO_CYC_CNT   = 28'h000_0010;
    localparam logic [27:0] MMIO_INST_CNT  = 28'h000_0014;
    localparam logic [27:0] MMIO_CNT_CLR   = 28'h000_0018;
    localparam logic [27:0] MMIO_BR_CNT    = 28'h000_001C;
    localparam logic [27:0] MMIO_OK_CNT    = 28'h000_0020;

    // ------------------------------------------------------------------
    // Instruction / address decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [1:0]  width;
    logic [1:0]  off;
    logic [27:0] mmio_off;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        in_dmem;
    logic        in_imem;
    logic        in_mmio;
    logic        is_not_nop;

    assign opcode     = mem_inst[6:0];
    assign width      = mem_inst[13:12];
    assign off        = mem_alu[1:0];
    assign mmio_off   = mem_alu[27:0];
    assign is_load    = (opcode == OPC_LOAD);
    assign is_store   = (opcode == OPC_STORE);
    assign is_branch  = (opcode == OPC_BRANCH);
    assign in_dmem    = (mem_alu[31:28] == 4'b0001);
    assign in_imem    = (mem_alu[31:29] == 3'b001);
    assign in_mmio    = (mem_alu[31:28] == 4'b1000);
    assign is_not_nop = (mem_inst != NOP);

    // ------------------------------------------------------------------
    // Store byte mask; misaligned halves and words produce an empty mask,
    // which silently drops the store.
    // ------------------------------------------------------------------
    logic [3:0] store_mask;

    // Byte-enable pattern from access width and byte offset
    always_comb begin
        store_mask = 4'b0000;
        case (width)
            2'b00:   store_mask = 4'b0001 << off;
            2'b01:   store_mask = off[0] ? 4'b0000 : (4'b0011 << off);
            2'b10:   store_mask = (off == 2'b00) ? 4'b1111 : 4'b0000;
            default: store_mask = 4'b0000;
        endcase
    end

    assign mem_din  = mem_rd2 << {off, 3'b000};
    assign mem_addr = mem_alu[DMEM_AW+1:2];
    assign dmem_en  = (is_load | is_store) & in_dmem;
    assign dmem_we  = (is_store & in_dmem & ~rst) ? store_mask : 4'b0000;
    assign imem_we  = (is_store & in_imem & ~rst) ? store_mask : 4'b0000;

    // ------------------------------------------------------------------
    // MMIO side-effect strobes (suppressed while reset flushes the stage)
    // ------------------------------------------------------------------
    logic mmio_rd;
    logic mmio_wr;
    logic cnt_clr;

    assign mmio_rd = is_load & in_mmio & ~rst;
    assign mmio_wr = is_store & in_mmio & ~rst;
    assign cnt_clr = mmio_wr & (mmio_off == MMIO_CNT_CLR);

    assign uart_tx_data_in        = mem_rd2[7:0];
    assign uart_tx_data_in_valid  = mmio_wr & (mmio_off == MMIO_UART_TX);
    assign uart_rx_data_out_ready = mmio_rd & (mmio_off == MMIO_UART_RX);

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] cyc_cnt_q;
    logic [31:0] cyc_cnt_d;
    logic [31:0] inst_cnt_q;
    logic [31:0] inst_cnt_d;
    logic [31:0] br_cnt_q;
    logic [31:0] br_cnt_d;
    logic [31:0] ok_cnt_q;
    logic [31:0] ok_cnt_d;

    // Next counter values; a clear beats any increment in the same cycle
    always_comb begin
        cyc_cnt_d  = cyc_cnt_q + 32'd1;
        inst_cnt_d = inst_cnt_q + {31'd0, is_not_nop};
        br_cnt_d   = br_cnt_q + {31'd0, is_branch};
        ok_cnt_d   = ok_cnt_q + {31'd0, is_branch & mem_br_suc};
        if (cnt_clr) begin
            cyc_cnt_d  = 32'd0;
            inst_cnt_d = 32'd0;
            br_cnt_d   = 32'd0;
            ok_cnt_d   = 32'd0;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q  <= 32'd0;
            inst_cnt_q <= 32'd0;
            br_cnt_q   <= 32'd0;
            ok_cnt_q   <= 32'd0;
        end else begin
            cyc_cnt_q  <= cyc_cnt_d;
            inst_cnt_q <= inst_cnt_d;
            br_cnt_q   <= br_cnt_d;
            ok_cnt_q   <= ok_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // MMIO read mux; counters are read before this cycle's increment.
    // Anything other than a mapped MMIO load yields 0.
    // ------------------------------------------------------------------
    logic [31:0] mmio_rdata_d;

    // Select the MMIO read value for the current load
    always_comb begin
        mmio_rdata_d = 32'd0;
        if (mmio_rd) begin
            case (mmio_off)
                MMIO_UART_STAT: mmio_rdata_d = {30'd0, uart_rx_data_out_valid, uart_tx_data_in_ready};
                MMIO_UART_RX:   mmio_rdata_d = {24'd0, uart_rx_data_out};
                MMIO_CYC_CNT:   mmio_rdata_d = cyc_cnt_q;
                MMIO_INST_CNT:  mmio_rdata_d = inst_cnt_q;
                MMIO_BR_CNT:    mmio_rdata_d = br_cnt_q;
                MMIO_OK_CNT:    mmio_rdata_d = ok_cnt_q;
                default:        mmio_rdata_d = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB pipeline registers
    // ------------------------------------------------------------------
    logic [31:0] wb_pc_q;
    logic [31:0] wb_alu_q;
    logic [31:0] wb_mmio_rdata_q;
    logic [31:0] wb_inst_q;

    // Capture the MEM results every cycle; reset injects a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_pc_q         <= 32'd0;
            wb_alu_q        <= 32'd0;
            wb_mmio_rdata_q <= 32'd0;
            wb_inst_q       <= NOP;
        end else begin
            wb_pc_q         <= mem_pc;
            wb_alu_q        <= mem_alu;
            wb_mmio_rdata_q <= mmio_rdata_d;
            wb_inst_q       <= mem_inst;
        end
    end

    assign wb_pc         = wb_pc_q;
    assign wb_alu        = wb_alu_q;
    assign wb_mmio_rdata = wb_mmio_rdata_q;
    assign wb_inst       = wb_inst_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM pipeline values: PC, ALU result, store operand, instruction and branch-success flag.
- Drives the data and instruction memory write ports, decodes and serves the MMIO space (UART, performance counters), and registers results into the MEM/WB pipeline registers.

Parameters:
- DMEM_AW, 14, dmem/imem word-address width (addr = mem_alu[DMEM_AW+1:2])
- NOP, 32'h00000013, instruction value loaded into wb_inst on reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_pc  in  32  PC of MEM instruction
- mem_alu  in  32  ALU result / effective address
- mem_rd2  in  32  store operand
- mem_inst  in  32  MEM instruction
- mem_br_suc  in  1  branch prediction was correct
- dmem_en  out  1  dmem enable
- dmem_we  out  4  dmem byte write enables
- imem_we  out  4  imem byte write enables
- mem_addr  out  DMEM_AW  shared dmem/imem word address
- mem_din  out  32  shifted store data
- uart_tx_data_in  out  8  TX byte
- uart_tx_data_in_valid  out  1  TX push
- uart_tx_data_in_ready  in  1  TX can accept
- uart_rx_data_out  in  8  RX byte
- uart_rx_data_out_valid  in  1  RX byte available
- uart_rx_data_out_ready  out  1  RX pop
- wb_pc  out  32  registered mem_pc
- wb_alu  out  32  registered mem_alu
- wb_mmio_rdata  out  32  registered MMIO read value
- wb_inst  out  32  registered mem_inst

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Decode:
  - load = opcode 0000011; store = opcode 0100011; branch = opcode 1100011.
  - off = mem_alu[1:0]; width from funct3[1:0] (00 byte, 01 half, 10 word).
- Address regions:
  - dmem when mem_alu[31:28]=0001.
  - imem (writes only) when mem_alu[31:29]=001.
  - MMIO when mem_alu[31:28]=1000.
  - Anything else: no side effects.
- Store data and byte enables:
  - mem_din = mem_rd2 << (8*off).
  - Byte mask: SB 0001<<off; SH 0011<<off, but 0000 if off[0]=1; SW 1111, but 0000 if off≠0.
  - Misaligned stores are dropped silently.
  - dmem_we = mask when store & dmem region, else 0.
  - imem_we = mask when store & imem region, else 0.
  - dmem_en = (load|store) & dmem region.
  - All of the above are combinational from MEM inputs. Dmem read data returns one cycle later; WB extracts and sign-extends.
- MMIO map (word offsets from 0x80000000):
  - 0x00 R: {30'b0, uart_rx_data_out_valid, uart_tx_data_in_ready}
  - 0x04 R: {24'b0, uart_rx_data_out}; asserts uart_rx_data_out_ready for this cycle only
  - 0x08 W: uart_tx_data_in = mem_rd2[7:0]; uart_tx_data_in_valid=1 this cycle only. If ready=0 the byte is lost; software polls 0x00 first.
  - 0x10 R: cycle counter
  - 0x14 R: instruction counter
  - 0x18 W: clear all four counters
  - 0x1C R: branch counter
  - 0x20 R: correct-prediction counter
  - Unmapped MMIO reads return 0; unmapped writes are ignored.
- Counters: 32-bit, wrap at 2^32 to 0.
  - Cycle counter: +1 every cycle.
  - Instruction counter: +1 when mem_inst ≠ NOP.
  - Branch counter: +1 when mem_inst is a branch.
  - Correct counter: +1 when branch & mem_br_suc.
  - A store to 0x18 in cycle N: all counters read 0 in cycle N+1. Clear wins over a simultaneous increment.
  - A counter read in cycle N captures the pre-increment value.
- MEM/WB registers: wb_pc, wb_alu, wb_mmio_rdata and wb_inst update every cycle when rst=0. Latency is 1 cycle.
- Reset values:
  - wb_pc=0, wb_alu=0, wb_mmio_rdata=0, wb_inst=NOP, all counters=0.
  - Combinational outputs (dmem_en, dmem_we, imem_we, mem_addr, mem_din, UART strobes) follow their inputs, with one exception: while rst=1, all write enables and UART strobes are forced to 0.
  - Reset asserted mid-operation discards the in-flight MEM instruction: no write and no UART push or pop.

Test Plan:
- SB, mem_alu=0x10000003, mem_rd2=0x000000AB -> dmem_we=1000, mem_din=0xAB000000, dmem_en=1, imem_we=0.
- SH at 0x10000001 -> dmem_we=0000. SW at 0x20000004 with rd2=0xDEADBEEF -> imem_we=1111, mem_addr=1, dmem_we=0.
- SW to 0x80000008, rd2=0x41, tx_ready=1 -> tx_valid=1 for one cycle, tx_data=0x41. LW 0x80000004 with rx_valid=1, rx_data=0x5A -> rx_ready=1 for one cycle, next cycle wb_mmio_rdata=0x5A.
- After reset, run 10 cycles with 4 non-NOP instructions, 2 of them branches and 1 with mem_br_suc=1. Read 0x10/0x14/0x1C/0x20 -> 10/4/2/1 (plus prior reads counted); store to 0x18 -> next cycle all counters 0.
- Force the cycle counter to 0xFFFFFFFF -> next cycle it reads 0 (wrap).
- Assert rst during a SW to 0x10000000 -> dmem_we=0; next cycle wb_inst=0x00000013 and the counters are 0.
